// File: rtl/freq_ratio_det_if.sv
// Measurement bus for freq_ratio_det: the sampled signal in, the period/high-time
// results and status flags out.
interface freq_ratio_det_if #(
  parameter int CNT_W = 8
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] hi_time;
  logic             valid;
  logic             locked;
  logic             ovf;

  // Driver of sig_in / consumer of the measurements
  modport master (output sig_in, input period, hi_time, valid, locked, ovf);
  // The detector itself
  modport slave  (input sig_in, output period, hi_time, valid, locked, ovf);
endinterface

// File: rtl/freq_ratio_det.sv
// Frequency/duty detector: measures rising-to-rising period and rising-to-falling
// high time of an asynchronous signal in clk cycles, flags saturation and reports
// lock after LOCK_N consecutive equal periods.
module freq_ratio_det #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 4
) (
  input logic           clk,
  input logic           rst,
  freq_ratio_det_if.slave bus
);
  localparam int               MW       = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_N);
  localparam logic [MW-1:0]    M_ONE    = MW'(1);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t           state_q, state_d;
  // sync_q[0]=s1, sync_q[1]=s2, sync_q[2]=s3
  logic [2:0]       sync_q, sync_d;
  // Fills with ones after reset; edges are only trusted once s3 holds a real
  // sample, so a level already high at reset is not mistaken for a rise.
  logic [2:0]       vld_pipe_q, vld_pipe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic             hi_seen_q, hi_seen_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] hi_time_q, hi_time_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             ovf_q, ovf_d;
  logic [MW-1:0]    match_q, match_d;
  logic             rise, fall;

  // Edge detection and next-state / output computation
  always_comb begin
    sync_d     = {sync_q[1:0], bus.sig_in};
    vld_pipe_d = {vld_pipe_q[1:0], 1'b1};
    rise       = vld_pipe_q[2] & sync_q[1] & ~sync_q[2];
    fall       = vld_pipe_q[2] & ~sync_q[1] & sync_q[2];

    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_lat_d  = hi_lat_q;
    hi_seen_d = hi_seen_q;
    period_d  = period_q;
    hi_time_d = hi_time_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    match_d   = match_q;
    // locked trails the match counter by one cycle
    locked_d  = (match_q == LOCK_MAX);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d   = MEAS;
          cnt_d     = CNT_ONE;
          hi_seen_d = 1'b0;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d  = cnt_q;
          hi_time_d = hi_seen_q ? hi_lat_q : cnt_q;
          valid_d   = 1'b1;
          ovf_d     = 1'b0;
          cnt_d     = CNT_ONE;
          hi_seen_d = 1'b0;
          // period_q still holds the previous measurement here
          if (match_q == '0 || cnt_q != period_q) match_d = M_ONE;
          else if (match_q != LOCK_MAX)           match_d = match_q + M_ONE;
        end else if (cnt_q == CNT_MAX) begin
          // No rise within the counter range: give up and wait for a fresh rise
          ovf_d    = 1'b1;
          locked_d = 1'b0;
          match_d  = '0;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall) begin
            hi_lat_d  = cnt_q;
            hi_seen_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      vld_pipe_q <= '0;
      cnt_q      <= '0;
      hi_lat_q   <= '0;
      hi_seen_q  <= 1'b0;
      period_q   <= '0;
      hi_time_q  <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      ovf_q      <= 1'b0;
      match_q    <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      vld_pipe_q <= vld_pipe_d;
      cnt_q      <= cnt_d;
      hi_lat_q   <= hi_lat_d;
      hi_seen_q  <= hi_seen_d;
      period_q   <= period_d;
      hi_time_q  <= hi_time_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      ovf_q      <= ovf_d;
      match_q    <= match_d;
    end
  end

  assign bus.period  = period_q;
  assign bus.hi_time = hi_time_q;
  assign bus.valid   = valid_q;
  assign bus.locked  = locked_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: doc/freq_ratio_det.md
FREQ_RATIO_DET -- requirements
Module: freq_ratio_det

Interface
REQ-001 Parameter CNT_W, default 8: width of the period and high-time counters and outputs.
REQ-002 Parameter LOCK_N, default 4 (>=2): number of consecutive identical period measurements required for lock.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sig_in  input  1  divided-clock or periodic signal under measurement, asynchronous to clk.
REQ-006 period  output  CNT_W  last measured rising-to-rising interval, in clk cycles.
REQ-007 hi_time  output  CNT_W  last measured rising-to-falling interval, in clk cycles.
REQ-008 valid  output  1  one-cycle pulse; period/hi_time updated this cycle.
REQ-009 locked  output  1  LOCK_N consecutive valid measurements had equal period.
REQ-010 ovf  output  1  counter saturated with no rising edge; sticky until next valid.

Function
REQ-011 sig_in SHALL pass a 2-flop synchronizer (s1, s2) plus a delay flop s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-012 FSM states SHALL be IDLE and MEAS only.
REQ-013 IDLE: cnt held at 0; on rise -> MEAS, cnt <= 1, hi_seen <= 0; no valid.
REQ-014 MEAS, no edge: cnt <= cnt + 1.
REQ-015 MEAS, fall: hi_lat <= cnt, hi_seen <= 1, cnt <= cnt + 1.
REQ-016 MEAS, rise: period <= cnt, hi_time <= (hi_seen ? hi_lat : cnt), valid <= 1, ovf <= 0, cnt <= 1, hi_seen <= 0; stay in MEAS.
REQ-017 rise and fall cannot coincide (derived from one signal); no priority rule needed.
REQ-018 MEAS, cnt == 2^CNT_W-1 with no rise in that cycle: ovf <= 1, locked <= 0, match count <= 0, -> IDLE; period/hi_time retain prior values; no valid.
REQ-019 Lock: on each valid, if match count == 0 or new period != previous period then match count <= 1, else match count <= min(match count + 1, LOCK_N).
REQ-020 locked SHALL be registered: 1 in the cycle after the valid that brings match count to LOCK_N; 0 the cycle after any mismatching valid.
REQ-021 Latency: rising sig_in sampled by s1 at edge N -> valid high in cycle N+3.
REQ-022 First rise after reset/IDLE only starts timing; first valid on second rise.
REQ-023 All outputs registered; no combinational path from sig_in to any output.
REQ-024 Counters wrap never: saturation handled solely by REQ-018.

Reset
REQ-025 With rst high at a posedge: state IDLE, s1/s2/s3 = 0, cnt = 0, period = 0, hi_time = 0, valid = 0, locked = 0, ovf = 0, match count = 0.
REQ-026 Reset mid-measurement SHALL discard the partial count; no valid for the interrupted period.
REQ-027 After rst deasserts, first valid SHALL require two fresh rises.

Verification
REQ-028 sig_in 2 high/2 low, synchronous to clk -> valid every 4 cycles, period=4, hi_time=2; locked=1 one cycle after 4th valid.
REQ-029 sig_in 1 high/2 low (divide-by-3 pattern) -> period=3, hi_time=1, locked after 4 valids.
REQ-030 Locked on period 4, switch to 3 high/3 low -> first valid period=6, hi_time=3, locked=0 next cycle; relocks after 3 more period-6 valids.
REQ-031 Locked, then sig_in held low -> 255 cycles after last rise ovf=1, locked=0, FSM IDLE; resume toggling -> ovf cleared on first new valid.
REQ-032 rst pulsed 1 cycle mid-period while locked -> all outputs 0 next cycle; no valid until second rise after release.
REQ-033 sig_in held high from reset -> no rise, no valid, ovf stays 0 (IDLE does not count).
